// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU in EX: one quotient bit per clock,
// result is {remainder, quotient}. The request is held until ready_o, and annul_i aborts.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   rem_reg;
    logic [DATA_W-1:0]   quo_reg;
    logic [DATA_W-1:0]   divisor_reg;
    logic                neg_a_reg;
    logic                neg_b_reg;
    logic                signed_reg;

    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   rem_step;
    logic [DATA_W-1:0]   quo_step;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // The magnitude of the most negative value is 2^(DATA_W-1) and still fits
    // when it is read as unsigned, so no special case is needed.
    assign neg_a = signed_div_i & opdata1_i[DATA_W-1];
    assign neg_b = signed_div_i & opdata2_i[DATA_W-1];
    assign abs_a = neg_a ? (~opdata1_i + 1'b1) : opdata1_i;
    assign abs_b = neg_b ? (~opdata2_i + 1'b1) : opdata2_i;

    // Restoring step. The trial result is one bit wider, and its MSB is the borrow.
    assign rem_shift = {rem_reg, quo_reg[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, divisor_reg};
    assign rem_step  = trial[DATA_W] ? rem_shift[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quo_step  = {quo_reg[DATA_W-2:0], ~trial[DATA_W]};

    assign quo_fix = (signed_reg && (neg_a_reg ^ neg_b_reg)) ? (~quo_reg + 1'b1) : quo_reg;
    assign rem_fix = (signed_reg && neg_a_reg) ? (~rem_reg + 1'b1) : rem_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= FREE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            neg_a_reg   <= 1'b0;
            neg_b_reg   <= 1'b0;
            signed_reg  <= 1'b0;
            ready_o     <= 1'b0;
            result_o    <= '0;
        end else begin
            case (state_reg)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_reg <= BYZERO;
                        end else begin
                            quo_reg     <= abs_a;
                            divisor_reg <= abs_b;
                            rem_reg     <= '0;
                            cnt_reg     <= '0;
                            neg_a_reg   <= neg_a;
                            neg_b_reg   <= neg_b;
                            signed_reg  <= signed_div_i;
                            state_reg   <= ON;
                        end
                    end
                end
                BYZERO: begin
                    // The architectural result is undefined here, so it is pinned to zero.
                    result_o  <= '0;
                    ready_o   <= 1'b1;
                    state_reg <= END;
                end
                ON: begin
                    if (annul_i) begin
                        state_reg <= FREE;
                        ready_o   <= 1'b0;
                        result_o  <= '0;
                        cnt_reg   <= '0;
                    end else if (cnt_reg != CNT_W'(DATA_W)) begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        result_o  <= {rem_fix, quo_fix};
                        ready_o   <= 1'b1;
                        state_reg <= END;
                    end
                end
                END: begin
                    // annul_i is ignored here because the stall has already been released.
                    if (!start_i) begin
                        state_reg <= FREE;
                        ready_o   <= 1'b0;
                        result_o  <= '0;
                    end
                end
                default: begin
                    state_reg <= FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed checks of div_unit against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Use plain language arithmetic. SV / and % truncate toward zero, which matches MIPS.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Start this task right after the acceptance edge. It counts edges until ready_o is seen.
    task automatic wait_ready(output int k, input bit wobble, input bit drop);
        k = 0;
        @(negedge clk);
        while (!ready_o && k < 40) begin
            if (wobble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom);
            end
            if (drop && k == 5) start_i = 1'b0;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit wobble, input bit drop);
        logic [63:0] exp;
        int k;
        exp = ref_div(sgn, a, b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        wait_ready(k, wobble, drop);
        if (b == 32'd0) check("bz_latency_ok", 64'(k >= 1 && k <= 2), 64'd1);
        else            check("latency", 64'(k), 64'd33);
        check("result", result_o, exp);
        $display("div sgn=%0d a=%h b=%h -> %h (exp %h) lat=%0d", sgn, a, b, result_o, exp, k);
        if (start_i) begin
            annul_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            annul_i = 1'b0;
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp);
            start_i = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    task automatic run_abort();
        int k;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) k++;
        end
        check("abort_no_ready", 64'(k), 64'd0);
        $display("abort divu 100/3 ready_cycles=%0d", k);
        run_div(1'b0, 32'd100, 32'd3, 1'b0, 1'b0);
    endtask

    task automatic run_reset_mid();
        int k;
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'hFFFF_FF9C;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        wait_ready(k, 1'b0, 1'b0);
        check("restart_latency", 64'(k), 64'd33);
        check("restart_result", result_o, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7));
        $display("reset-restart div -100/7 -> %h lat=%0d", result_o, k);
        // Assert reset while the result is held, away from any clock edge.
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] a, b;
        logic s;
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        run_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div(1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);

        // If annul and start are high together in FREE, the request is not accepted.
        @(negedge clk);
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("annul_wins", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;

        run_abort();
        run_reset_mid();

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 20);
                1:       b = 32'hFFFF_FFFF - $urandom_range(0, 20);
                2:       b = (i % 10 == 0) ? 32'd0 : $urandom;
                default: b = $urandom;
            endcase
            run_div(s, a, b, 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
